// File: rtl/simpson_pkg.sv
// Shared definitions for the Simpson's-rule operand-entry path:
// FSM state encoding, operand count and operand order.
package simpson_pkg;

    localparam int NUM_OPERANDS = 6;
    localparam int IDX_W        = 3;

    localparam logic [IDX_W-1:0] LAST_IDX = 3'd5;

    // Order in which operands are keyed into the integrator
    localparam logic [IDX_W-1:0] OP_A0 = 3'd0;
    localparam logic [IDX_W-1:0] OP_A1 = 3'd1;
    localparam logic [IDX_W-1:0] OP_A2 = 3'd2;
    localparam logic [IDX_W-1:0] OP_A3 = 3'd3;
    localparam logic [IDX_W-1:0] OP_LO = 3'd4;
    localparam logic [IDX_W-1:0] OP_HI = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_PRESS  = 3'd2,
        ST_GAP    = 3'd3,
        ST_SETTLE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/operand_loader_phase_timer.sv
// Down-counter shared by all timed phases of the operand loader.
// A phase loaded with N reports expiry on its N-th cycle.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expired
);

    logic [CNT_W-1:0] count_r;

    // Load a new phase length or count down, saturating at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= value;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r <= CNT_W'(1));

endmodule

// File: rtl/operand_loader.sv
// Drives the switch/button operand-entry protocol of the Simpson's-rule fsm
// for one six-operand job, then returns the captured result via valid/ready.
module operand_loader
    import simpson_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int SETUP_CYC  = 1,
    parameter int PRESS_CYC  = 6,
    parameter int GAP_CYC    = 3,
    parameter int SETTLE_CYC = 20,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a0,
    input  logic [WIDTH-1:0] op_a1,
    input  logic [WIDTH-1:0] op_a2,
    input  logic [WIDTH-1:0] op_a3,
    input  logic [WIDTH-1:0] op_lo,
    input  logic [WIDTH-1:0] op_hi,
    output logic [WIDTH-1:0] sw,
    output logic             btn,
    input  logic [WIDTH-1:0] result_in,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    input  logic             res_ready,
    output logic             busy
);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] PRESS_LD  = CNT_W'(PRESS_CYC);
    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYC);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);

    state_t            state_r, state_s;
    logic [IDX_W-1:0]  idx_r, idx_s, idx_inc_s;
    logic [WIDTH-1:0]  sw_r, sw_s;
    logic              btn_r, btn_s;
    logic              res_valid_r, res_valid_s;
    logic [WIDTH-1:0]  res_data_r, res_data_s;
    logic [WIDTH-1:0]  ops_r [NUM_OPERANDS];
    logic              accept_s;
    logic              timer_load_s;
    logic [CNT_W-1:0]  timer_val_s;
    logic              timer_exp_s;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load_s),
        .value   (timer_val_s),
        .expired (timer_exp_s)
    );

    assign idx_inc_s = idx_r + IDX_W'(1);

    // Next-state, phase timer loads and next values of every registered output
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        sw_s         = sw_r;
        btn_s        = btn_r;
        res_valid_s  = res_valid_r;
        res_data_s   = res_data_r;
        accept_s     = 1'b0;
        timer_load_s = 1'b0;
        timer_val_s  = {CNT_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (start_valid) begin
                    accept_s     = 1'b1;
                    idx_s        = {IDX_W{1'b0}};
                    sw_s         = op_a0;
                    state_s      = ST_SETUP;
                    timer_load_s = 1'b1;
                    timer_val_s  = SETUP_LD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (timer_exp_s) begin
                    btn_s        = 1'b1;
                    state_s      = ST_PRESS;
                    timer_load_s = 1'b1;
                    timer_val_s  = PRESS_LD;
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_PRESS: begin
                if (timer_exp_s) begin
                    btn_s        = 1'b0;
                    timer_load_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        state_s     = ST_SETTLE;
                        timer_val_s = SETTLE_LD;
                    end else begin
                        state_s     = ST_GAP;
                        timer_val_s = GAP_LD;
                    end
                end else begin
                    state_s = ST_PRESS;
                end
            end
            ST_GAP: begin
                // sw only moves here, after btn has been low for the gap
                if (timer_exp_s) begin
                    idx_s        = idx_inc_s;
                    sw_s         = ops_r[idx_inc_s];
                    state_s      = ST_SETUP;
                    timer_load_s = 1'b1;
                    timer_val_s  = SETUP_LD;
                end else begin
                    state_s = ST_GAP;
                end
            end
            ST_SETTLE: begin
                if (timer_exp_s) begin
                    res_data_s  = result_in;
                    res_valid_s = 1'b1;
                    state_s     = ST_DONE;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_DONE: begin
                if (res_valid_r && res_ready) begin
                    res_valid_s = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                btn_s       = 1'b0;
                res_valid_s = 1'b0;
            end
        endcase
    end

    // Control state and registered protocol outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= {IDX_W{1'b0}};
            sw_r        <= {WIDTH{1'b0}};
            btn_r       <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= {WIDTH{1'b0}};
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            sw_r        <= sw_s;
            btn_r       <= btn_s;
            res_valid_r <= res_valid_s;
            res_data_r  <= res_data_s;
        end
    end

    // Operand snapshot taken at accept so the host may change inputs afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                ops_r[i] <= {WIDTH{1'b0}};
            end
        end else if (accept_s) begin
            ops_r[OP_A0] <= op_a0;
            ops_r[OP_A1] <= op_a1;
            ops_r[OP_A2] <= op_a2;
            ops_r[OP_A3] <= op_a3;
            ops_r[OP_LO] <= op_lo;
            ops_r[OP_HI] <= op_hi;
        end
    end

    assign start_ready = (state_r == ST_IDLE);
    assign busy        = (state_r != ST_IDLE);
    assign sw          = sw_r;
    assign btn         = btn_r;
    assign res_valid   = res_valid_r;
    assign res_data    = res_data_r;

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Transmit side of the switch/button operand-entry protocol consumed by the Simpson's-rule `fsm` block.
- Accepts one job: six 16-bit operands in order a_0, a_1, a_2, a_3, lower bound a, upper bound b.
- Presents each operand on `sw` and strobes `btn` with fixed setup, press and gap timing, then waits a settle time.
- Captures `fsm.result` and returns it over a valid/ready handshake. Lets a host or self-test drive the integrator without manual entry.

Parameters:
- WIDTH, 16: operand, switch and result width.
- SETUP_CYC, 1: cycles `sw` is stable before `btn` rises (≥1).
- PRESS_CYC, 6: cycles `btn` is held high (≥1).
- GAP_CYC, 3: cycles after `btn` falls before `sw` changes to the next operand (≥1).
- SETTLE_CYC, 20: cycles after the final `btn` fall before `result_in` is captured (≥1).
- CNT_W, 8: phase-timer width; every *_CYC value must be < 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_valid  in  1  job request.
- start_ready  out  1  high only in IDLE.
- op_a0, op_a1, op_a2, op_a3, op_lo, op_hi  in  WIDTH each  operands; sampled only on accept.
- sw  out  WIDTH  switch bus to fsm.
- btn  out  1  button strobe to fsm.
- result_in  in  WIDTH  fsm result.
- res_valid  out  1  captured result available.
- res_data  out  WIDTH  captured result.
- res_ready  in  1  result consumer ready.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release):
  - sw=0, btn=0, res_valid=0, res_data=0, busy=0.
  - state=IDLE, index=0, timer=0.
  - Asserting reset mid-job drops `btn` immediately and abandons the job; no partial result is produced.
- States: IDLE, SETUP, PRESS, GAP, SETTLE, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid at a clock edge: latch all six operands, index=0, sw=op[0], go to SETUP with timer=SETUP_CYC.
- SETUP: at expiry, btn<=1 and go to PRESS with timer=PRESS_CYC.
- PRESS:
  - At expiry, btn<=0.
  - If index==5, go to SETTLE with timer=SETTLE_CYC.
  - Otherwise go to GAP with timer=GAP_CYC.
- GAP: at expiry, index++, sw<=op[index+1], go to SETUP.
- SETTLE: at expiry, res_data<=result_in, res_valid<=1, go to DONE.
- DONE:
  - res_valid and res_data are held stable until res_valid&&res_ready at a clock edge.
  - Then res_valid<=0 and go to IDLE.
  - A new job cannot be accepted in the same cycle as the result transfer; earliest accept is the next edge.
- Timing with accept at edge 0 and period P=SETUP_CYC+PRESS_CYC+GAP_CYC:
  - Operand i appears on sw at edge i·P.
  - btn rises at edge i·P+SETUP_CYC.
  - btn falls at edge i·P+SETUP_CYC+PRESS_CYC.
  - res_valid rises at edge 5·P+SETUP_CYC+PRESS_CYC+SETTLE_CYC; this is 77 with defaults.
- `sw` changes only on accept and at GAP expiry; it is never changed while btn=1. After a job, sw holds op_hi.
- `btn` is a registered output; it is high for exactly PRESS_CYC cycles per operand, 6 pulses per job.
- start_valid is ignored while busy; operand inputs may change freely after accept.
- res_ready already high when res_valid rises: the transfer completes at the next edge; res_valid is high for exactly 1 cycle.
- `result_in` is sampled only at SETTLE expiry; no width conversion.

Decomposition:
- Shared package `simpson_pkg` holds:
  - the state encoding constants;
  - NUM_OPERANDS=6, IDX_W=3, LAST_IDX=5;
  - the operand-order constants (A0..A3, LO, HI).
- One sub-module, `phase_timer`: CNT_W down-counter with load/value inputs and an `expired` output. It is shared by the SETUP, PRESS, GAP and SETTLE phases.

Test Plan:
- Reset: hold rst_n=0 with start_valid=1 -> sw=0, btn=0, res_valid=0, busy=0. One cycle after release -> start_ready=1.
- Single job (7,0,0,0,7,16); responder model latches sw on each btn rise and drives result_in=16'h29B6 after the 6th rise:
  - btn rises at cycles 1, 11, 21, 31, 41, 51, each high for 6 cycles.
  - Latched values are 7, 0, 0, 0, 7, 16.
  - res_valid rises at cycle 77 with res_data=16'h29B6.
- Backpressure: res_ready=0 for 10 cycles after job (1,3,0,0,2,8):
  - res_valid and res_data remain stable; start_ready=0; a start_valid pulse is ignored.
  - Release res_ready -> IDLE on the next edge.
- Back-to-back: res_ready tied 1, start_valid tied 1 with jobs (4,2,1,0,1,6) then (1,1,2,1,2,5):
  - The second accept occurs 1 cycle after the first transfer.
  - The responder sees 12 operands in order and never sees sw change while btn=1.
- Reset mid-job: assert rst_n=0 during PRESS of operand index 2 -> btn=0 immediately with no res_valid. A new job (4,10,0,2,5,12) restarts at operand 0 with nominal timing.
- Parameter variant SETUP_CYC=2, PRESS_CYC=1, GAP_CYC=1, SETTLE_CYC=1 -> btn rises at cycles 2, 6, 10, 14, 18, 22; res_valid rises at cycle 24.
